// File: rtl/reservation_station.sv
// Reservation station: buffers up to SIZE issued instructions, wakes operands from two CDBs
// and hands the lowest-index ready entry to its functional unit over valid/ready.
module reservation_station #(
    parameter int SIZE       = 16,
    parameter int STATION_ID = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        delete_tagged,
    input  logic        clear_tags,
    input  logic [1:0]  issue1_stat_select,
    input  logic [31:0] issue1_data1,
    input  logic [31:0] issue1_data2,
    input  logic        issue1_valid1,
    input  logic        issue1_valid2,
    input  logic [5:0]  issue1_src1,
    input  logic [5:0]  issue1_src2,
    input  logic [5:0]  issue1_arn,
    input  logic [5:0]  issue1_rrn,
    input  logic [31:0] issue1_imm,
    input  logic [31:0] issue1_address,
    input  logic [7:0]  issue1_pid,
    input  logic        issue1_tag,
    input  logic        issue1_jump,
    input  logic [1:0]  issue2_stat_select,
    input  logic [31:0] issue2_data1,
    input  logic [31:0] issue2_data2,
    input  logic        issue2_valid1,
    input  logic        issue2_valid2,
    input  logic [5:0]  issue2_src1,
    input  logic [5:0]  issue2_src2,
    input  logic [5:0]  issue2_arn,
    input  logic [5:0]  issue2_rrn,
    input  logic [31:0] issue2_imm,
    input  logic [31:0] issue2_address,
    input  logic [7:0]  issue2_pid,
    input  logic        issue2_tag,
    input  logic        issue2_jump,
    input  logic [5:0]  cdb1_arn,
    input  logic [5:0]  cdb1_rrn,
    input  logic [31:0] cdb1_data,
    input  logic [5:0]  cdb2_arn,
    input  logic [5:0]  cdb2_rrn,
    input  logic [31:0] cdb2_data,
    output logic        exec_valid,
    input  logic        exec_ready,
    output logic [31:0] exec_data1,
    output logic [31:0] exec_data2,
    output logic [31:0] exec_imm,
    output logic [31:0] exec_address,
    output logic [7:0]  exec_pid,
    output logic [5:0]  exec_arn,
    output logic [5:0]  exec_rrn,
    output logic        exec_tag,
    output logic        exec_jump,
    output logic [15:0] capacity,
    output logic        overflow
);
    localparam int IW = $clog2(SIZE);
    localparam logic [1:0] SID = 2'(STATION_ID);

    typedef struct packed {
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] imm;
        logic [31:0] address;
        logic [7:0]  pid;
        logic [5:0]  arn;
        logic [5:0]  rrn;
        logic        tag;
        logic        jump;
    } pkt_t;

    typedef struct packed {
        pkt_t       p;
        logic       v1;
        logic       v2;
        logic [5:0] src1;
        logic [5:0] src2;
    } entry_t;

    logic [SIZE-1:0] vld_q, vld_d;
    entry_t          ent_q [SIZE];
    entry_t          ent_d [SIZE];
    pkt_t            exec_q, exec_d;
    logic            exec_valid_q, exec_valid_d;
    logic [15:0]     cap_q, cap_d;
    logic            ovf_q, ovf_d;
    entry_t          new1, new2;
    logic            clr_eff, sel_ok, load, take1, take2, f1_ok, f2_ok, slot2_ok;
    logic [IW-1:0]   sel_idx, f1, f2, slot2;

    function automatic logic hit1(input logic [5:0] s);
        return (cdb1_rrn != 6'd0) && ((s == cdb1_arn) || (s == cdb1_rrn));
    endfunction

    function automatic logic hit2(input logic [5:0] s);
        return (cdb2_rrn != 6'd0) && ((s == cdb2_arn) || (s == cdb2_rrn));
    endfunction

    // Bus 1 takes precedence when both buses broadcast a matching tag.
    function automatic entry_t snoop(input entry_t e);
        entry_t r;
        r = e;
        if (!e.v1) begin
            if (hit1(e.src1)) begin r.p.data1 = cdb1_data; r.v1 = 1'b1; end
            else if (hit2(e.src1)) begin r.p.data1 = cdb2_data; r.v1 = 1'b1; end
        end
        if (!e.v2) begin
            if (hit1(e.src2)) begin r.p.data2 = cdb1_data; r.v2 = 1'b1; end
            else if (hit2(e.src2)) begin r.p.data2 = cdb2_data; r.v2 = 1'b1; end
        end
        return r;
    endfunction

    always_comb begin
        clr_eff = clear_tags && !delete_tagged;
        new1 = '{p: '{data1: issue1_data1, data2: issue1_data2, imm: issue1_imm,
                      address: issue1_address, pid: issue1_pid, arn: issue1_arn, rrn: issue1_rrn,
                      tag: issue1_tag && !clr_eff, jump: issue1_jump},
                 v1: issue1_valid1, v2: issue1_valid2, src1: issue1_src1, src2: issue1_src2};
        new2 = '{p: '{data1: issue2_data1, data2: issue2_data2, imm: issue2_imm,
                      address: issue2_address, pid: issue2_pid, arn: issue2_arn, rrn: issue2_rrn,
                      tag: issue2_tag && !clr_eff, jump: issue2_jump},
                 v1: issue2_valid1, v2: issue2_valid2, src1: issue2_src1, src2: issue2_src2};
        new1 = snoop(new1);
        new2 = snoop(new2);
    end

    always_comb begin
        vld_d        = vld_q;
        ovf_d        = ovf_q;
        exec_d       = exec_q;
        exec_valid_d = exec_valid_q;
        sel_ok       = 1'b0;
        sel_idx      = '0;
        f1_ok        = 1'b0;
        f2_ok        = 1'b0;
        f1           = '0;
        f2           = '0;
        for (int i = 0; i < SIZE; i++) begin
            ent_d[i] = snoop(ent_q[i]);
            if (!sel_ok && vld_q[i] && ent_q[i].v1 && ent_q[i].v2 &&
                !(delete_tagged && ent_q[i].p.tag)) begin
                sel_ok  = 1'b1;
                sel_idx = IW'(i);
            end
            if (!vld_q[i]) begin
                if (!f1_ok) begin f1_ok = 1'b1; f1 = IW'(i); end
                else if (!f2_ok) begin f2_ok = 1'b1; f2 = IW'(i); end
            end
        end

        load = sel_ok && (!exec_valid_q || exec_ready);
        if (load) begin
            exec_d         = ent_q[sel_idx].p;
            exec_valid_d   = 1'b1;
            vld_d[sel_idx] = 1'b0;
        end else if (exec_ready || (delete_tagged && exec_q.tag)) begin
            exec_valid_d = 1'b0;
        end
        if (clr_eff) exec_d.tag = 1'b0;

        for (int i = 0; i < SIZE; i++) begin
            if (delete_tagged && ent_q[i].p.tag) vld_d[i] = 1'b0;
            else if (clr_eff) ent_d[i].p.tag = 1'b0;
        end

        // New issues only land in slots that were free before this edge.
        take1    = !delete_tagged && (issue1_stat_select == SID);
        take2    = !delete_tagged && (issue2_stat_select == SID);
        slot2    = take1 ? f2 : f1;
        slot2_ok = take1 ? f2_ok : f1_ok;
        if (take1) begin
            if (f1_ok) begin vld_d[f1] = 1'b1; ent_d[f1] = new1; end
            else ovf_d = 1'b1;
        end
        if (take2) begin
            if (slot2_ok) begin vld_d[slot2] = 1'b1; ent_d[slot2] = new2; end
            else ovf_d = 1'b1;
        end

        cap_d = '0;
        for (int i = 0; i < SIZE; i++) cap_d = cap_d + 16'(!vld_d[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q        <= '0;
            exec_valid_q <= 1'b0;
            exec_q       <= '0;
            cap_q        <= 16'(SIZE);
            ovf_q        <= 1'b0;
        end else begin
            vld_q        <= vld_d;
            exec_valid_q <= exec_valid_d;
            exec_q       <= exec_d;
            cap_q        <= cap_d;
            ovf_q        <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign exec_valid   = exec_valid_q;
    assign exec_data1   = exec_q.data1;
    assign exec_data2   = exec_q.data2;
    assign exec_imm     = exec_q.imm;
    assign exec_address = exec_q.address;
    assign exec_pid     = exec_q.pid;
    assign exec_arn     = exec_q.arn;
    assign exec_rrn     = exec_q.rrn;
    assign exec_tag     = exec_q.tag;
    assign exec_jump    = exec_q.jump;
    assign capacity     = cap_q;
    assign overflow     = ovf_q;
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus random traffic, all checked each
// cycle against a slot-array reference model of the station.
module tb_reservation_station;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, delete_tagged, clear_tags, exec_ready;
    logic [1:0]  issue1_stat_select, issue2_stat_select;
    logic [31:0] issue1_data1, issue1_data2, issue1_imm, issue1_address;
    logic [31:0] issue2_data1, issue2_data2, issue2_imm, issue2_address;
    logic        issue1_valid1, issue1_valid2, issue1_tag, issue1_jump;
    logic        issue2_valid1, issue2_valid2, issue2_tag, issue2_jump;
    logic [5:0]  issue1_src1, issue1_src2, issue1_arn, issue1_rrn;
    logic [5:0]  issue2_src1, issue2_src2, issue2_arn, issue2_rrn;
    logic [7:0]  issue1_pid, issue2_pid;
    logic [5:0]  cdb1_arn, cdb1_rrn, cdb2_arn, cdb2_rrn;
    logic [31:0] cdb1_data, cdb2_data;
    logic        exec_valid, exec_tag, exec_jump, overflow;
    logic [31:0] exec_data1, exec_data2, exec_imm, exec_address;
    logic [7:0]  exec_pid;
    logic [5:0]  exec_arn, exec_rrn;
    logic [15:0] capacity;

    reservation_station dut (
        .clk(clk), .reset(reset), .delete_tagged(delete_tagged), .clear_tags(clear_tags),
        .issue1_stat_select(issue1_stat_select), .issue1_data1(issue1_data1),
        .issue1_data2(issue1_data2), .issue1_valid1(issue1_valid1), .issue1_valid2(issue1_valid2),
        .issue1_src1(issue1_src1), .issue1_src2(issue1_src2), .issue1_arn(issue1_arn),
        .issue1_rrn(issue1_rrn), .issue1_imm(issue1_imm), .issue1_address(issue1_address),
        .issue1_pid(issue1_pid), .issue1_tag(issue1_tag), .issue1_jump(issue1_jump),
        .issue2_stat_select(issue2_stat_select), .issue2_data1(issue2_data1),
        .issue2_data2(issue2_data2), .issue2_valid1(issue2_valid1), .issue2_valid2(issue2_valid2),
        .issue2_src1(issue2_src1), .issue2_src2(issue2_src2), .issue2_arn(issue2_arn),
        .issue2_rrn(issue2_rrn), .issue2_imm(issue2_imm), .issue2_address(issue2_address),
        .issue2_pid(issue2_pid), .issue2_tag(issue2_tag), .issue2_jump(issue2_jump),
        .cdb1_arn(cdb1_arn), .cdb1_rrn(cdb1_rrn), .cdb1_data(cdb1_data),
        .cdb2_arn(cdb2_arn), .cdb2_rrn(cdb2_rrn), .cdb2_data(cdb2_data),
        .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_data1(exec_data1),
        .exec_data2(exec_data2), .exec_imm(exec_imm), .exec_address(exec_address),
        .exec_pid(exec_pid), .exec_arn(exec_arn), .exec_rrn(exec_rrn), .exec_tag(exec_tag),
        .exec_jump(exec_jump), .capacity(capacity), .overflow(overflow)
    );

    typedef struct {
        logic [31:0] d1, d2, imm, addr;
        logic [7:0]  pid;
        logic [5:0]  arn, rrn, s1, s2;
        logic        v1, v2, tag, jump;
    } ment_t;

    ment_t      m_e [16];
    bit         m_v [16];
    ment_t      m_x;
    bit         m_xv;
    int         m_cap;
    bit         m_ovf;
    int         n_checks = 0;
    int         n_err = 0;
    logic [7:0] pid_ctr = 8'd0;

    function automatic logic [159:0] pk(input ment_t e);
        return 160'({e.d1, e.d2, e.imm, e.addr, e.pid, e.arn, e.rrn, e.tag, e.jump});
    endfunction

    function automatic logic [159:0] obs_pkt();
        return 160'({exec_data1, exec_data2, exec_imm, exec_address, exec_pid, exec_arn,
                     exec_rrn, exec_tag, exec_jump});
    endfunction

    function automatic bit on_bus(input logic [5:0] s, input logic [5:0] a, input logic [5:0] r);
        return (r != 6'd0) && ((s == a) || (s == r));
    endfunction

    function automatic ment_t wake(input ment_t e);
        ment_t r = e;
        if (!e.v1 && on_bus(e.s1, cdb1_arn, cdb1_rrn)) begin r.d1 = cdb1_data; r.v1 = 1'b1; end
        else if (!e.v1 && on_bus(e.s1, cdb2_arn, cdb2_rrn)) begin r.d1 = cdb2_data; r.v1 = 1'b1; end
        if (!e.v2 && on_bus(e.s2, cdb1_arn, cdb1_rrn)) begin r.d2 = cdb1_data; r.v2 = 1'b1; end
        else if (!e.v2 && on_bus(e.s2, cdb2_arn, cdb2_rrn)) begin r.d2 = cdb2_data; r.v2 = 1'b1; end
        return r;
    endfunction

    function automatic ment_t incoming(input int n);
        ment_t e;
        if (n == 1) e = '{issue1_data1, issue1_data2, issue1_imm, issue1_address, issue1_pid,
                          issue1_arn, issue1_rrn, issue1_src1, issue1_src2, issue1_valid1,
                          issue1_valid2, issue1_tag, issue1_jump};
        else        e = '{issue2_data1, issue2_data2, issue2_imm, issue2_address, issue2_pid,
                          issue2_arn, issue2_rrn, issue2_src1, issue2_src2, issue2_valid1,
                          issue2_valid2, issue2_tag, issue2_jump};
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
        m_x   = '{default: '0};
        m_xv  = 1'b0;
        m_cap = 16;
        m_ovf = 1'b0;
    endtask

    task automatic model_step();
        ment_t ne [16];
        bit    nv [16];
        bit    busy [16];
        int    sel = -1;
        int    slot;
        bit    clr = clear_tags && !delete_tagged;
        if (!m_xv || exec_ready)
            for (int i = 0; i < 16; i++)
                if (m_v[i] && m_e[i].v1 && m_e[i].v2 && !(delete_tagged && m_e[i].tag)) begin
                    sel = i;
                    break;
                end
        for (int i = 0; i < 16; i++) begin
            nv[i] = m_v[i]; busy[i] = m_v[i]; ne[i] = wake(m_e[i]);
        end
        if (sel >= 0) begin m_x = m_e[sel]; m_xv = 1'b1; nv[sel] = 1'b0; end
        else if (exec_ready || (delete_tagged && m_x.tag)) m_xv = 1'b0;
        if (clr) m_x.tag = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (delete_tagged && m_e[i].tag) nv[i] = 1'b0;
            else if (clr) ne[i].tag = 1'b0;
        end
        if (!delete_tagged) begin
            for (int n = 1; n <= 2; n++) begin
                if (((n == 1) ? issue1_stat_select : issue2_stat_select) == 2'd1) begin
                    slot = -1;
                    for (int i = 0; i < 16; i++) if (!busy[i]) begin slot = i; break; end
                    if (slot < 0) m_ovf = 1'b1;
                    else begin
                        busy[slot] = 1'b1;
                        nv[slot]   = 1'b1;
                        ne[slot]   = wake(incoming(n));
                        if (clr) ne[slot].tag = 1'b0;
                    end
                end
            end
        end
        m_cap = 0;
        for (int i = 0; i < 16; i++) begin
            m_v[i] = nv[i]; m_e[i] = ne[i];
            if (!nv[i]) m_cap++;
        end
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("exec_valid", 160'(exec_valid), 160'(m_xv));
        chk("capacity", 160'(capacity), 160'(m_cap));
        chk("overflow", 160'(overflow), 160'(m_ovf));
        if (m_xv) chk("exec_pkt", obs_pkt(), pk(m_x));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle();
        issue1_stat_select = 2'd3; issue2_stat_select = 2'd3;
        cdb1_arn = 6'd0; cdb1_rrn = 6'd0; cdb1_data = '0;
        cdb2_arn = 6'd0; cdb2_rrn = 6'd0; cdb2_data = '0;
        delete_tagged = 1'b0; clear_tags = 1'b0; exec_ready = 1'b1;
    endtask

    task automatic iss(input int n, input logic [31:0] d1, input logic [31:0] d2,
                       input logic v1, input logic v2, input logic [5:0] s1,
                       input logic [5:0] s2, input logic tg);
        pid_ctr = pid_ctr + 8'd1;
        if (n == 1) begin
            issue1_stat_select = 2'd1; issue1_data1 = d1; issue1_data2 = d2;
            issue1_valid1 = v1; issue1_valid2 = v2; issue1_src1 = s1; issue1_src2 = s2;
            issue1_tag = tg; issue1_jump = pid_ctr[0]; issue1_pid = pid_ctr;
            issue1_arn = pid_ctr[5:0]; issue1_rrn = 6'(pid_ctr + 8'd1);
            issue1_imm = d1 ^ 32'hA5A5_0000; issue1_address = {24'h0040_00, pid_ctr};
        end else begin
            issue2_stat_select = 2'd1; issue2_data1 = d1; issue2_data2 = d2;
            issue2_valid1 = v1; issue2_valid2 = v2; issue2_src1 = s1; issue2_src2 = s2;
            issue2_tag = tg; issue2_jump = pid_ctr[1]; issue2_pid = pid_ctr;
            issue2_arn = pid_ctr[5:0]; issue2_rrn = 6'(pid_ctr + 8'd2);
            issue2_imm = d2 ^ 32'h0000_5A5A; issue2_address = {24'h0080_00, pid_ctr};
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        iss(1, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        iss(2, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_model();
        chk("reset_capacity", 160'(capacity), 160'(16));
        chk("reset_exec_pkt", obs_pkt(), 160'(0));
        reset = 1'b1;

        // single ready ALU issue
        iss(1, 32'd5, 32'd7, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0);
        cycle();
        chk("t1_cap_after_issue", 160'(capacity), 160'(15));
        chk("t1_not_yet_valid", 160'(exec_valid), 160'(0));
        idle();
        cycle();
        chk("t1_exec_valid", 160'(exec_valid), 160'(1));
        chk("t1_data1", 160'(exec_data1), 160'(32'd5));
        chk("t1_data2", 160'(exec_data2), 160'(32'd7));
        chk("t1_cap_restored", 160'(capacity), 160'(16));
        cycle();

        // CDB2 wakeup of operand 2
        iss(1, 32'd1, 32'd0, 1'b1, 1'b0, 6'd0, 6'h23, 1'b0);
        cycle();
        idle();
        repeat (2) cycle();
        cdb2_rrn = 6'h23; cdb2_arn = 6'h3E; cdb2_data = 32'hDEAD;
        cycle();
        chk("t2_wait_valid", 160'(exec_valid), 160'(0));
        idle();
        cycle();
        chk("t2_exec_valid", 160'(exec_valid), 160'(1));
        chk("t2_data2", 160'(exec_data2), 160'(32'hDEAD));

        // same-edge bypass
        iss(1, 32'd0, 32'd4, 1'b0, 1'b1, 6'h11, 6'd0, 1'b0);
        cdb1_rrn = 6'h11; cdb1_arn = 6'h3D; cdb1_data = 32'd9;
        cycle();
        idle();
        cycle();
        chk("t3_exec_valid", 160'(exec_valid), 160'(1));
        chk("t3_data1", 160'(exec_data1), 160'(32'd9));

        // fill, overflow, then drain
        for (int k = 0; k < 8; k++) begin
            iss(1, 32'(k), 32'(k + 100), 1'b0, 1'b0, 6'h30, 6'h30, 1'b0);
            iss(2, 32'(k + 200), 32'(k + 300), 1'b0, 1'b0, 6'h30, 6'h30, 1'b0);
            cycle();
        end
        idle();
        cycle();
        chk("t4_full_cap", 160'(capacity), 160'(0));
        chk("t4_no_ovf_yet", 160'(overflow), 160'(0));
        iss(1, 32'hBAD1, 32'hBAD1, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0);
        iss(2, 32'hBAD2, 32'hBAD2, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0);
        cycle();
        chk("t4_overflow", 160'(overflow), 160'(1));
        chk("t4_cap_zero", 160'(capacity), 160'(0));
        idle();
        cdb1_rrn = 6'h30; cdb1_data = 32'h1234_5678;
        cycle();
        idle();
        repeat (18) cycle();
        chk("t4_drained", 160'(capacity), 160'(16));

        // reset mid-operation with a packet in flight
        iss(1, 32'd1, 32'd2, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0);
        cycle();
        idle();
        cycle();
        reset = 1'b0;
        #2;
        model_reset();
        check_model();
        chk("t5_reset_ovf", 160'(overflow), 160'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;

        // delete_tagged removes only the tagged middle entry
        iss(1, 32'd1, 32'd1, 1'b1, 1'b0, 6'd0, 6'h2A, 1'b0);
        iss(2, 32'd2, 32'd2, 1'b1, 1'b0, 6'd0, 6'h2A, 1'b1);
        cycle();
        idle();
        iss(1, 32'd3, 32'd3, 1'b1, 1'b0, 6'd0, 6'h2A, 1'b0);
        cycle();
        idle();
        chk("t6_cap_three", 160'(capacity), 160'(13));
        delete_tagged = 1'b1;
        cycle();
        chk("t6_cap_after_del", 160'(capacity), 160'(14));
        idle();
        cdb2_rrn = 6'h2A; cdb2_data = 32'h77;
        cycle();
        idle();
        repeat (4) cycle();

        // clear_tags keeps all three, each leaving untagged
        iss(1, 32'd4, 32'd4, 1'b1, 1'b0, 6'd0, 6'h2B, 1'b0);
        iss(2, 32'd5, 32'd5, 1'b1, 1'b0, 6'd0, 6'h2B, 1'b1);
        cycle();
        idle();
        iss(1, 32'd6, 32'd6, 1'b1, 1'b0, 6'd0, 6'h2B, 1'b0);
        cycle();
        idle();
        clear_tags = 1'b1;
        cycle();
        chk("t7_cap_after_clr", 160'(capacity), 160'(13));
        idle();
        cdb1_rrn = 6'h2B; cdb1_data = 32'h88;
        cycle();
        idle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t7_exec_valid", 160'(exec_valid), 160'(1));
            chk("t7_exec_tag", 160'(exec_tag), 160'(0));
        end
        cycle();

        // backpressure hold, then in-order drain
        exec_ready = 1'b0;
        iss(1, 32'h11, 32'h12, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0);
        iss(2, 32'h21, 32'h22, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0);
        cycle();
        idle();
        exec_ready = 1'b0;
        cycle();
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("t8_hold_data1", 160'(exec_data1), 160'(32'h11));
        end
        exec_ready = 1'b1;
        cycle();
        chk("t8_second_data1", 160'(exec_data1), 160'(32'h21));
        cycle();
        chk("t8_empty", 160'(exec_valid), 160'(0));

        // random traffic
        for (int k = 0; k < 600; k++) begin
            idle();
            issue1_stat_select = 2'($urandom_range(0, 3));
            issue2_stat_select = 2'($urandom_range(0, 3));
            issue1_data1 = $urandom; issue1_data2 = $urandom; issue1_imm = $urandom;
            issue2_data1 = $urandom; issue2_data2 = $urandom; issue2_imm = $urandom;
            issue1_address = $urandom; issue2_address = $urandom;
            issue1_pid = 8'($urandom); issue2_pid = 8'($urandom);
            issue1_arn = 6'($urandom); issue1_rrn = 6'($urandom);
            issue2_arn = 6'($urandom); issue2_rrn = 6'($urandom);
            issue1_valid1 = 1'($urandom_range(0, 1)); issue1_valid2 = 1'($urandom_range(0, 1));
            issue2_valid1 = 1'($urandom_range(0, 1)); issue2_valid2 = 1'($urandom_range(0, 1));
            issue1_src1 = 6'($urandom_range(1, 12)); issue1_src2 = 6'($urandom_range(1, 12));
            issue2_src1 = 6'($urandom_range(1, 12)); issue2_src2 = 6'($urandom_range(1, 12));
            issue1_tag = ($urandom_range(0, 99) < 30); issue2_tag = ($urandom_range(0, 99) < 30);
            issue1_jump = 1'($urandom_range(0, 1)); issue2_jump = 1'($urandom_range(0, 1));
            cdb1_rrn = 6'($urandom_range(0, 12)); cdb1_arn = 6'($urandom_range(0, 12));
            cdb2_rrn = 6'($urandom_range(0, 12)); cdb2_arn = 6'($urandom_range(0, 12));
            cdb1_data = $urandom; cdb2_data = $urandom;
            delete_tagged = ($urandom_range(0, 99) < 4);
            clear_tags = ($urandom_range(0, 99) < 4);
            exec_ready = ($urandom_range(0, 99) < 70);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Downstream neighbour of the dual-issue dispatch stage; one instance per station class (BRANCH, ALU, LS).
- Accepts up to two issued instructions per cycle whose stat_select equals STATION_ID.
- Holds each entry until both operands are valid, snooping both common data buses.
- Hands the lowest-index ready entry to its functional unit over a valid/ready handshake, and reports free capacity back to dispatch.

Parameters:
- SIZE, 16, number of entries (2..16).
- STATION_ID, 1, stat_select code accepted (0 BRANCH, 1 ALU, 2 LS; 3 = NONE is never accepted).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- delete_tagged  input  1  flush all speculative (tagged) entries.
- clear_tags  input  1  branch resolved correct; drop all tag bits.
- issueN_stat_select  input  2  destination station, N=1,2.
- issueN_data1/data2  input  32  operand values.
- issueN_valid1/valid2  input  1  operand valid.
- issueN_src1/src2  input  6  operand rename tags.
- issueN_arn/rrn  input  6  architectural/renamed destination.
- issueN_imm  input  32  immediate.
- issueN_address  input  32  instruction address.
- issueN_pid  input  8  decoded instruction id.
- issueN_tag/jump  input  1  speculative tag; jump flag.
- cdbK_arn/rrn  input  6  broadcast destination, K=1,2.
- cdbK_data  input  32  broadcast result.
- exec_valid  output  1  execute packet valid.
- exec_ready  input  1  functional unit accepts.
- exec_*  output  -  registered packet: data1, data2, imm, address, pid, arn, rrn, tag, jump (same widths as issue).
- capacity  output  16  number of free entries, zero-extended.
- overflow  output  1  sticky: an issue was dropped for lack of space.

Behaviour:
- Reset (reset=0, async):
  - All entries invalid; exec_valid=0; exec_* = 0.
  - capacity=SIZE; overflow=0.
  - Dispatch operation resumes on the first edge after reset rises.
- Accept:
  - issueN is taken only if issueN_stat_select==STATION_ID.
  - issue1 gets the lowest free index, issue2 the next lowest free index.
  - If no free entry remains, that issue is dropped and overflow is set (sticky until reset).
- CDB match:
  - Operand src matches bus K iff cdbK_rrn!=0 and (src==cdbK_arn or src==cdbK_rrn).
  - On match, data:=cdbK_data and valid:=1.
  - If both buses match, bus 1 wins.
  - Snooping applies to resident entries and to operands being written this cycle (same-edge bypass), so no wakeup is lost.
- Select/output:
  - Output register loads when (!exec_valid || exec_ready) and some valid entry has valid1 && valid2.
  - The lowest-index such entry is chosen; it is freed on the same edge and exec_valid=1.
  - If no ready entry exists and exec_ready=1, then exec_valid:=0.
  - While exec_valid && !exec_ready, exec_* is held stable.
- Latency:
  - An entry written at edge N with both operands valid (or completed via bypass) is selectable in the following cycle.
  - Earliest exec_valid is after edge N+1.
- Capacity:
  - Registered count of free entries after each edge, including entries freed by select and by delete_tagged on that edge.
  - Dispatch reads it one cycle stale; this is acceptable because dispatch issues at most once per 4-state loop.
- delete_tagged (synchronous):
  - Invalidates every entry with tag=1.
  - If the held exec packet has tag=1, clears exec_valid.
  - Accepts no new issues that cycle.
  - Selection that cycle considers only untagged entries.
- clear_tags (synchronous): clears the tag bit of all entries and of the exec packet.
- Priority when both flush inputs assert in the same cycle: delete_tagged over clear_tags.
- Mid-operation reset: immediate return to the reset state; the packet in flight is lost.

Test Plan:
- Issue1 ALU (STATION_ID=1) with valid1=valid2=1, data1=5, data2=7, exec_ready=1 -> exec_valid=1 two edges later with data1=5, data2=7; capacity 16→15→16.
- Issue with valid2=0, src2=0x23; later cdb2_rrn=0x23, cdb2_data=0xDEAD -> entry wakes; exec_data2=0xDEAD one cycle after the broadcast.
- Issue with src1=0x11 in the same cycle as cdb1_rrn=0x11, data=9 -> bypass; exec_data1=9 and no stall.
- Fill all 16 entries with unready operands; then issue two more -> capacity=0, overflow=1, existing entries intact.
- Three entries, middle one tag=1; assert delete_tagged -> capacity rises by 1, only the untagged entries execute. Repeat with clear_tags -> all three execute with exec_tag=0.
- exec_ready=0 for 5 cycles with two ready entries -> exec_* stable; entry 0 emitted then entry 1 on consecutive ready cycles.
